// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART receive FIFO
package uart_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEFAULT_DEPTH = 16;
    localparam int FERR_CNT_W    = 8;
    localparam logic [FERR_CNT_W-1:0] FERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through byte queue behind a UART receiver
// with sticky overflow and saturating frame-error counter.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BYTE_W-1:0]        rdata,
    input  logic                     rdata_ready,
    input  logic                     ferr,
    output logic [BYTE_W-1:0]        dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [FERR_CNT_W-1:0]    ferr_count,
    input  logic                     clr_status
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              ferr_q;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;
    logic              ferr_rise;

    assign full       = (count == CNT_W'(DEPTH));
    assign dout_valid = (count != '0);
    assign pop        = dout_valid & dout_ready;
    // A full queue still accepts a byte when the head leaves in the same cycle.
    assign push       = rdata_ready & (~full | pop);
    assign drop       = rdata_ready & full & ~pop;
    assign ferr_rise  = ferr & ~ferr_q;
    assign dout       = dout_valid ? mem[rd_ptr] : '0;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ferr_q     <= 1'b0;
            overflow   <= 1'b0;
            ferr_count <= '0;
        end else begin
            ferr_q <= ferr;
            // Clear wins over a same-cycle drop or frame-error edge.
            if (clr_status) begin
                overflow   <= 1'b0;
                ferr_count <= '0;
            end else begin
                if (drop) begin
                    overflow <= 1'b1;
                end
                if (ferr_rise && ferr_count != FERR_CNT_MAX) begin
                    ferr_count <= ferr_count + FERR_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rdata = 8'h00;
    logic       rdata_ready = 1'b0;
    logic       ferr = 1'b0;
    logic       dout_ready = 1'b0;
    logic       clr_status = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] ferr_count;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] mq[$];
    logic       m_ov;
    int         m_fc;
    logic       m_fprev;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdata(rdata), .rdata_ready(rdata_ready),
        .ferr(ferr), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .count(count), .overflow(overflow), .ferr_count(ferr_count),
        .clr_status(clr_status)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_dout();
        return (mq.size() != 0) ? mq[0] : 8'h00;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ov    = 1'b0;
        m_fc    = 0;
        m_fprev = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the reference model across the edge, settle.
    task automatic cycle(input logic rr, input logic [7:0] d, input logic dr,
                         input logic fe, input logic clr);
        bit pop, push, full;
        rdata_ready = rr; rdata = d; dout_ready = dr; ferr = fe; clr_status = clr;
        @(posedge clk);
        if (!rst) begin
            pop  = dr && (mq.size() != 0);
            full = (mq.size() == DEPTH);
            push = rr && (!full || pop);
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(d);
            if (clr) begin
                m_ov = 1'b0;
                m_fc = 0;
            end else begin
                if (rr && full && !pop) m_ov = 1'b1;
                if (fe && !m_fprev && m_fc < 255) m_fc++;
            end
            m_fprev = fe;
        end
        #1;
    endtask

    task automatic apply_reset();
        rdata_ready = 1'b0; dout_ready = 1'b0; ferr = 1'b0; clr_status = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        compared += 5;
        if (count !== 5'd0) begin mismatched++; $display("FAIL reset_count got %0d exp 0", count); end
        if (dout_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
        if (dout !== 8'h00) begin mismatched++; $display("FAIL reset_dout got %h exp 00", dout); end
        if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        if (ferr_count !== 8'd0) begin mismatched++; $display("FAIL reset_ferr_count got %0d exp 0", ferr_count); end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h41; exp_seq[1] = 8'h42; exp_seq[2] = 8'h43;
        for (int i = 0; i < 3; i++) cycle(1'b1, exp_seq[i], 1'b0, 1'b0, 1'b0);
        compared += 3;
        if (count !== 5'd3) begin mismatched++; $display("FAIL basic_count got %0d exp 3", count); end
        if (dout !== 8'h41) begin mismatched++; $display("FAIL basic_head got %h exp 41", dout); end
        if (dout_valid !== 1'b1) begin mismatched++; $display("FAIL basic_valid got %b exp 1", dout_valid); end
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (dout !== exp_seq[i]) begin mismatched++; $display("FAIL basic_order[%0d] got %h exp %h", i, dout, exp_seq[i]); end
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        compared += 2;
        if (count !== 5'd0) begin mismatched++; $display("FAIL basic_drain_count got %0d exp 0", count); end
        if (dout_valid !== 1'b0) begin mismatched++; $display("FAIL basic_drain_valid got %b exp 0", dout_valid); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        compared += 2;
        if (count !== 5'd16) begin mismatched++; $display("FAIL ovf_count got %0d exp 16", count); end
        if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        for (int i = 0; i < 16; i++) begin
            compared++;
            if (dout !== 8'(i) || dout_valid !== 1'b1) begin
                mismatched++; $display("FAIL ovf_drain[%0d] got %h/%b exp %h/1", i, dout, dout_valid, 8'(i));
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        compared++;
        if (dout_valid !== 1'b0) begin mismatched++; $display("FAIL ovf_extra_byte got valid %b dout %h exp 0", dout_valid, dout); end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        compared += 2;
        if (count !== 5'd16) begin mismatched++; $display("FAIL fullpp_count got %0d exp 16", count); end
        if (overflow !== 1'b0) begin mismatched++; $display("FAIL fullpp_overflow got %b exp 0", overflow); end
        for (int i = 0; i < 16; i++) begin
            compared++;
            if (dout !== exp_dout()) begin mismatched++; $display("FAIL fullpp_drain[%0d] got %h exp %h", i, dout, exp_dout()); end
            if (i == 15) begin
                compared++;
                if (dout !== 8'hAA) begin mismatched++; $display("FAIL fullpp_last got %h exp aa", dout); end
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sent[$];
        int         got;
        apply_reset();
        got = 0;
        for (int i = 0; i < 41; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if (dout_valid) begin
                compared++;
                if (dout !== sent[got]) begin mismatched++; $display("FAIL b2b_order[%0d] got %h exp %h", got, dout, sent[got]); end
                got++;
            end
            if (i < 40) sent.push_back(d);
            cycle(i < 40, d, 1'b1, 1'b0, 1'b0);
            compared++;
            if (count > 5'd1) begin mismatched++; $display("FAIL b2b_count got %0d exp <=1", count); end
        end
        compared += 2;
        if (got !== 40) begin mismatched++; $display("FAIL b2b_total got %0d exp 40", got); end
        if (dout_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_empty got %b exp 0", dout_valid); end
    endtask

    task automatic test_ferr();
        apply_reset();
        for (int i = 0; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 5; k++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            for (int k = 0; k < 5; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        compared++;
        if (ferr_count !== 8'd3) begin mismatched++; $display("FAIL ferr_three got %0d exp 3", ferr_count); end
        for (int e = 0; e < 300; e++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        compared += 2;
        if (ferr_count !== 8'd255) begin mismatched++; $display("FAIL ferr_saturate got %0d exp 255", ferr_count); end
        if (overflow !== 1'b1) begin mismatched++; $display("FAIL ferr_ovf_pre got %b exp 1", overflow); end
        cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
        compared += 3;
        if (ferr_count !== 8'd0) begin mismatched++; $display("FAIL clr_ferr_count got %0d exp 0", ferr_count); end
        if (overflow !== 1'b0) begin mismatched++; $display("FAIL clr_overflow got %b exp 0", overflow); end
        if (count !== 5'd16) begin mismatched++; $display("FAIL clr_count got %0d exp 16", count); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        compared += 3;
        if (count !== 5'd0) begin mismatched++; $display("FAIL rstmid_count got %0d exp 0", count); end
        if (dout_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_valid got %b exp 0", dout_valid); end
        if (overflow !== 1'b0) begin mismatched++; $display("FAIL rstmid_overflow got %b exp 0", overflow); end
        cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        rdata_ready = 1'b0;
        #1;
        compared++;
        if (count !== 5'd0) begin mismatched++; $display("FAIL rstmid_strobe_ignored got %0d exp 0", count); end
        rdata_ready = 1'b1; rdata = 8'h55;
        #1;
        compared++;
        if (dout_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_no_bypass got %b exp 0", dout_valid); end
        cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        compared += 2;
        if (dout !== 8'h55) begin mismatched++; $display("FAIL rstmid_push_dout got %h exp 55", dout); end
        if (dout_valid !== 1'b1) begin mismatched++; $display("FAIL rstmid_push_valid got %b exp 1", dout_valid); end
    endtask

    task automatic test_random();
        logic fe;
        apply_reset();
        fe = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int pr;
            pr = ((i / 150) % 2 == 0) ? 20 : 80;
            if ($urandom_range(0, 99) < 15) fe = ~fe;
            cycle($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < pr,
                  fe, $urandom_range(0, 99) < 2);
            compared += 5;
            if (count !== 5'(mq.size())) begin mismatched++; $display("FAIL rnd_count @%0d got %0d exp %0d", i, count, mq.size()); end
            if (dout_valid !== (mq.size() != 0)) begin mismatched++; $display("FAIL rnd_valid @%0d got %b", i, dout_valid); end
            if (dout !== exp_dout()) begin mismatched++; $display("FAIL rnd_dout @%0d got %h exp %h", i, dout, exp_dout()); end
            if (overflow !== m_ov) begin mismatched++; $display("FAIL rnd_overflow @%0d got %b exp %b", i, overflow, m_ov); end
            if (ferr_count !== 8'(m_fc)) begin mismatched++; $display("FAIL rnd_ferr_count @%0d got %0d exp %0d", i, ferr_count, m_fc); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_ferr();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rdata  input  8  received byte from the UART receiver.
REQ-005 rdata_ready  input  1  one-cycle strobe; rdata is valid in that cycle.
REQ-006 ferr  input  1  receiver frame-error flag; level, may stay high.
REQ-007 dout  output  8  head-of-queue byte toward the transmitter.
REQ-008 dout_valid  output  1  dout holds a valid byte.
REQ-009 dout_ready  input  1  consumer accepts dout this cycle.
REQ-010 count  output  $clog2(DEPTH)+1  number of bytes stored, 0..DEPTH.
REQ-011 overflow  output  1  sticky: at least one byte was dropped.
REQ-012 ferr_count  output  8  count of ferr rising edges; saturates at 255.
REQ-013 clr_status  input  1  synchronous clear of overflow and ferr_count.

Function
REQ-014 Push: rdata_ready=1 writes rdata at the write pointer when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-015 Pop: dout_valid=1 and dout_ready=1 removes the head byte; dout_ready while dout_valid=0 has no effect.
REQ-016 Queue is first-word-fall-through: dout always equals the oldest stored byte while dout_valid=1.
REQ-017 Latency: a byte pushed into an empty queue at edge N appears on dout with dout_valid=1 from edge N onward, i.e. one cycle after the strobe; there is no same-cycle bypass.
REQ-018 dout_valid SHALL equal (count != 0).
REQ-019 Pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no special handling.
REQ-020 count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-021 Overflow: rdata_ready=1 with count==DEPTH and no pop drops the byte, leaves storage and pointers unchanged, and sets overflow.
REQ-022 ferr edge detect: registered copy of ferr; rising edge (ferr=1, previous ferr=0) increments ferr_count unless it is 255.
REQ-023 clr_status=1 clears overflow and ferr_count to 0; clear takes priority over a same-cycle set or increment.
REQ-024 ferr does not gate pushes; bytes and errors are tracked independently.
REQ-025 Underflow is impossible: pop is qualified by dout_valid.

Reset
REQ-026 rst=1 asynchronously sets pointers, count, overflow, ferr_count and the ferr edge register to 0; dout_valid=0; dout=0.
REQ-027 Storage contents are not reset; stored bytes are discarded when reset is asserted mid-operation.
REQ-028 A rdata_ready strobe coincident with rst is ignored; operation resumes on the first edge after rst deasserts.

Structure
REQ-029 Shared package uart_pkg SHALL hold the byte-width constant (8), the default DEPTH, and the ferr_count width/saturation constant.
REQ-030 Single module; the storage array, pointers and status logic are in-line with no sub-module instances.

Verification
REQ-031 Reset then push 0x41,0x42,0x43 with dout_ready=0 -> count=3, dout=0x41, dout_valid=1; then dout_ready=1 for 3 cycles -> dout 0x41,0x42,0x43 in order, count=0, dout_valid=0.
REQ-032 DEPTH=16: push 17 bytes 0x00..0x10 with no pop -> count=16, overflow=1, dout sequence 0x00..0x0F on drain, 0x10 never appears.
REQ-033 With count=16, push 0xAA and pop in the same cycle -> count stays 16, overflow=0, 0xAA emerges last.
REQ-034 Push/pop 40 bytes continuously with dout_ready=1 -> pointers wrap twice, output order matches input order, count never exceeds 1.
REQ-035 ferr pulsed high 3 times (held 5 cycles each) -> ferr_count=3; 300 edges -> ferr_count=255; clr_status=1 -> ferr_count=0, overflow=0.
REQ-036 Assert rst with count=5 -> next cycle count=0, dout_valid=0, overflow=0; a following push of 0x55 appears on dout one cycle later.
